// File: rtl/rv_sdram_bridge_pkg.sv
// Shared types and constants for the RISC-V 32-bit bus to SDRAM RV-port bridge.
package rv_sdram_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LO_ISSUE = 3'd1,
        ST_LO_WAIT  = 3'd2,
        ST_HI_ISSUE = 3'd3,
        ST_HI_WAIT  = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    localparam int RV_RD_LAT   = 3;
    localparam int RV_ADDR_MSB = 20;

    // A write half with no strobes set carries no data and may be dropped.
    function automatic logic half_is_empty(input logic [1:0] strb, input logic is_write);
        return is_write && (strb == 2'b00);
    endfunction

endpackage

// File: rtl/rv_sdram_bridge_toggle_req_port.sv
// Toggle request/acknowledge port: owns rv_req, the pending compare and the
// read-latency counter, and reports one done pulse per issued halfword.
module rv_sdram_bridge_toggle_req_port
    import rv_sdram_bridge_pkg::*;
#(
    parameter int RD_LAT = RV_RD_LAT
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_issue,
    input  logic i_is_read,
    input  logic rv_req_ack,
    output logic rv_req,
    output logic o_done
);
    logic       r_wait;
    logic [3:0] r_cnt;
    logic       w_obs;

    assign w_obs  = r_wait && (rv_req == rv_req_ack);
    // Reads finish when the counter reaches its last count, i.e. RD_LAT edges after ack.
    assign o_done = (w_obs && (!i_is_read || (RD_LAT == 0))) || (r_cnt == 4'd1);

    // Request toggle, wait-for-ack flag and read-latency countdown.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rv_req <= rv_req_ack;
            r_wait <= 1'b0;
            r_cnt  <= 4'd0;
        end else begin
            if (r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (i_issue) begin
                rv_req <= ~rv_req;
                r_wait <= 1'b1;
            end else if (w_obs) begin
                r_wait <= 1'b0;
                if (i_is_read && (RD_LAT != 0)) begin
                    r_cnt <= 4'(RD_LAT);
                end
            end
        end
    end

endmodule

// File: rtl/rv_sdram_bridge.sv
// Bridges the CPU's 32-bit valid/ready bus onto the 16-bit toggle-handshake
// RV port: one or two halfword transactions, low half first.
module rv_sdram_bridge
    import rv_sdram_bridge_pkg::*;
#(
    parameter int RD_LAT          = RV_RD_LAT,
    parameter bit SKIP_EMPTY_HALF = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    input  logic        sdram_busy,
    output logic [19:0] rv_addr,
    output logic [15:0] rv_din,
    output logic [1:0]  rv_ds,
    output logic        rv_we,
    output logic        rv_req,
    input  logic        rv_req_ack,
    input  logic [15:0] rv_dout
);
    state_t                 r_state;
    logic [RV_ADDR_MSB-2:0] r_word;
    logic [31:0]            r_wdata;
    logic [31:0]            r_rdata;
    logic [3:0]             r_wstrb;

    logic w_is_write;
    logic w_is_read;
    logic w_issue;
    logic w_done;
    logic w_skip_lo;
    logic w_skip_hi;
    logic w_unused;

    assign w_is_write = (r_wstrb != 4'b0000);
    assign w_is_read  = !w_is_write;
    assign w_issue    = (r_state == ST_LO_ISSUE) || (r_state == ST_HI_ISSUE);
    assign w_skip_lo  = SKIP_EMPTY_HALF && half_is_empty(mem_wstrb[1:0], mem_wstrb != 4'b0000);
    assign w_skip_hi  = SKIP_EMPTY_HALF && half_is_empty(r_wstrb[3:2], w_is_write);
    assign w_unused   = ^{mem_addr[31:RV_ADDR_MSB+1], mem_addr[1:0]};

    rv_sdram_bridge_toggle_req_port #(
        .RD_LAT (RD_LAT)
    ) u_port (
        .clk        (clk),
        .resetn     (resetn),
        .i_issue    (w_issue),
        .i_is_read  (w_is_read),
        .rv_req_ack (rv_req_ack),
        .rv_req     (rv_req),
        .o_done     (w_done)
    );

    // Transaction sequencer with registered CPU and RV-port outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_word    <= '0;
            r_wdata   <= 32'h0;
            r_wstrb   <= 4'h0;
            r_rdata   <= 32'h0;
            mem_ready <= 1'b0;
            mem_rdata <= 32'h0;
            rv_addr   <= 20'h0;
            rv_din    <= 16'h0;
            rv_ds     <= 2'b00;
            rv_we     <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            case (r_state)
                // mem_ready still high here means the CPU has not yet dropped the old request.
                ST_IDLE: begin
                    if (mem_valid && !sdram_busy && !mem_ready) begin
                        r_word  <= mem_addr[RV_ADDR_MSB:2];
                        r_wdata <= mem_wdata;
                        r_wstrb <= mem_wstrb;
                        r_rdata <= 32'h0;
                        r_state <= w_skip_lo ? ST_HI_ISSUE : ST_LO_ISSUE;
                    end
                end
                ST_LO_ISSUE: begin
                    rv_addr <= {r_word, 1'b0};
                    rv_din  <= r_wdata[15:0];
                    rv_ds   <= w_is_write ? r_wstrb[1:0] : 2'b11;
                    rv_we   <= w_is_write;
                    r_state <= ST_LO_WAIT;
                end
                ST_LO_WAIT: begin
                    if (w_done) begin
                        if (w_is_read) begin
                            r_rdata[15:0] <= rv_dout;
                        end
                        r_state <= w_skip_hi ? ST_DONE : ST_HI_ISSUE;
                    end
                end
                ST_HI_ISSUE: begin
                    rv_addr <= {r_word, 1'b1};
                    rv_din  <= r_wdata[31:16];
                    rv_ds   <= w_is_write ? r_wstrb[3:2] : 2'b11;
                    rv_we   <= w_is_write;
                    r_state <= ST_HI_WAIT;
                end
                ST_HI_WAIT: begin
                    if (w_done) begin
                        if (w_is_read) begin
                            r_rdata[31:16] <= rv_dout;
                        end
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    mem_ready <= 1'b1;
                    mem_rdata <= r_rdata;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_sdram_bridge.sv
// Self-checking bench: a CPU-level word model predicts halfword requests and
// read data, while a controller model serves the toggle-handshake port.
module tb_rv_sdram_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        sdram_busy;
    logic [19:0] rv_addr;
    logic [15:0] rv_din;
    logic [1:0]  rv_ds;
    logic        rv_we;
    logic        rv_req;
    logic        rv_req_ack;
    logic [15:0] rv_dout;

    always #5 clk = ~clk;

    rv_sdram_bridge dut (
        .clk        (clk),
        .resetn     (resetn),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .sdram_busy (sdram_busy),
        .rv_addr    (rv_addr),
        .rv_din     (rv_din),
        .rv_ds      (rv_ds),
        .rv_we      (rv_we),
        .rv_req     (rv_req),
        .rv_req_ack (rv_req_ack),
        .rv_dout    (rv_dout)
    );

    typedef struct packed {
        logic [19:0] addr;
        logic        we;
        logic [1:0]  ds;
        logic [15:0] din;
    } req_t;

    typedef struct packed {
        logic        is_rd;
        logic [31:0] data;
    } rsp_t;

    req_t        exp_req_q[$];
    req_t        req_log[$];
    rsp_t        exp_rsp_q[$];
    logic [15:0] hw_mem [logic [19:0]];
    logic [31:0] ref_mem [logic [18:0]];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] last_rdata = 32'h0;

    // controller model state
    logic        c_busy = 1'b0;
    int          c_cnt = 0;
    logic        c_unst = 1'b0;
    req_t        c_cap;
    int          d_cnt = 0;
    logic [15:0] d_val = 16'h0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, want);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired or event missing", name);
    endtask

    function automatic logic [31:0] ref_word(input logic [18:0] w);
        return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    endfunction

    function automatic logic [15:0] hw_word(input logic [19:0] a);
        return hw_mem.exists(a) ? hw_mem[a] : 16'h0;
    endfunction

    // Predict halfword requests and the CPU response from the word-level rules.
    task automatic expect_op(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [18:0] w;
        logic [31:0] old_w;
        logic [31:0] new_w;
        req_t        r;
        rsp_t        p;
        w = a[20:2];
        if (s == 4'b0000) begin
            r = '{addr: {w, 1'b0}, we: 1'b0, ds: 2'b11, din: 16'h0};
            exp_req_q.push_back(r);
            r.addr = {w, 1'b1};
            exp_req_q.push_back(r);
            p = '{is_rd: 1'b1, data: ref_word(w)};
        end else begin
            if (s[1:0] != 2'b00) begin
                r = '{addr: {w, 1'b0}, we: 1'b1, ds: s[1:0], din: d[15:0]};
                exp_req_q.push_back(r);
            end
            if (s[3:2] != 2'b00) begin
                r = '{addr: {w, 1'b1}, we: 1'b1, ds: s[3:2], din: d[31:16]};
                exp_req_q.push_back(r);
            end
            old_w = ref_word(w);
            for (int b = 0; b < 4; b++) begin
                new_w[8*b +: 8] = s[b] ? d[8*b +: 8] : old_w[8*b +: 8];
            end
            ref_mem[w] = new_w;
            p = '{is_rd: 1'b0, data: 32'h0};
        end
        exp_rsp_q.push_back(p);
    endtask

    task automatic cpu_op(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        expect_op(a, d, s);
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        mem_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mem_ready !== 1'b1 && n < 400);
        if (mem_ready !== 1'b1) fail_now("ready_timeout");
        mem_valid = 1'b0;
        @(negedge clk);
    endtask

    // Controller model: accepts a toggle, acks after a few cycles, and drives
    // read data only in the single cycle RD_LAT edges after the ack is seen.
    initial begin
        logic [15:0] hw;
        req_t        e;
        rv_req_ack = 1'b1;
        rv_dout    = 16'hA5A5;
        forever begin
            @(negedge clk);
            if (d_cnt > 0) begin
                d_cnt--;
                rv_dout = (d_cnt == 0) ? d_val : 16'hA5A5;
            end else begin
                rv_dout = 16'hA5A5;
            end
            if (c_busy) begin
                if (resetn === 1'b1 && {rv_addr, rv_we, rv_ds, rv_din} !== c_cap) c_unst = 1'b1;
                if (c_cnt == 0) begin
                    if (c_cap.we) begin
                        hw = hw_word(c_cap.addr);
                        if (c_cap.ds[0]) hw[7:0] = c_cap.din[7:0];
                        if (c_cap.ds[1]) hw[15:8] = c_cap.din[15:8];
                        hw_mem[c_cap.addr] = hw;
                    end else begin
                        d_val = hw_word(c_cap.addr);
                        d_cnt = 3;
                    end
                    rv_req_ack = ~rv_req_ack;
                    c_busy     = 1'b0;
                    check("req_fields_stable", 32'(c_unst), 32'h0);
                end else begin
                    c_cnt--;
                end
            end else if (rv_req === ~rv_req_ack) begin
                c_cap  = '{addr: rv_addr, we: rv_we, ds: rv_ds, din: rv_din};
                req_log.push_back(c_cap);
                c_busy = 1'b1;
                c_cnt  = 2;
                c_unst = 1'b0;
                if (exp_req_q.size() == 0) begin
                    fail_now("unexpected_req");
                end else begin
                    e = exp_req_q.pop_front();
                    check("req_addr", 32'(rv_addr), 32'(e.addr));
                    check("req_we", 32'(rv_we), 32'(e.we));
                    check("req_ds", 32'(rv_ds), 32'(e.ds));
                    if (e.we) check("req_din", 32'(rv_din), 32'(e.din));
                end
            end
        end
    end

    // Response compare: every mem_ready cycle is matched against the model.
    initial begin
        logic prev_ready;
        rsp_t p;
        prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && mem_ready === 1'b1) begin
                if (prev_ready) fail_now("ready_pulse_width");
                if (exp_rsp_q.size() == 0) begin
                    fail_now("spurious_ready");
                end else begin
                    p = exp_rsp_q.pop_front();
                    if (p.is_rd) check("mem_rdata", mem_rdata, p.data);
                    last_rdata = mem_rdata;
                end
            end
            prev_ready = (mem_ready === 1'b1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic r0;
        int   n;
        int   tg;
        rsp_t pd;
        resetn     = 1'b0;
        mem_valid  = 1'b0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        mem_wstrb  = 4'h0;
        sdram_busy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rv_req", 32'(rv_req), 32'h1);
        check("rst_mem_ready", 32'(mem_ready), 32'h0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
        check("rst_rv_addr", 32'(rv_addr), 32'h0);
        check("rst_rv_din", 32'(rv_din), 32'h0);
        check("rst_rv_ds_we", 32'({rv_ds, rv_we}), 32'h0);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_no_toggle", 32'(rv_req), 32'h1);

        // Read reassembly
        hw_mem[20'h091A2]  = 16'hBEEF;
        hw_mem[20'h091A3]  = 16'hDEAD;
        ref_mem[19'h048D1] = 32'hDEADBEEF;
        req_log.delete();
        cpu_op(32'h0001_2344, 32'h0, 4'b0000);
        check("rd_req_count", 32'(req_log.size()), 32'd2);
        if (req_log.size() >= 2) begin
            check("rd_addr_lo", 32'(req_log[0].addr), 32'h000091A2);
            check("rd_addr_hi", 32'(req_log[1].addr), 32'h000091A3);
            check("rd_we_ds", 32'({req_log[0].we, req_log[0].ds, req_log[1].we, req_log[1].ds}), 32'h1B);
        end
        check("rd_word", last_rdata, 32'hDEADBEEF);

        // Full write; sdram_busy pulsed mid-transaction must not matter
        req_log.delete();
        fork
            cpu_op(32'h0000_0100, 32'hCAFEF00D, 4'b1111);
            begin : busy_mid
                repeat (3) @(negedge clk);
                sdram_busy = 1'b1;
                repeat (8) @(negedge clk);
                sdram_busy = 1'b0;
            end
        join
        check("wr_req_count", 32'(req_log.size()), 32'd2);
        if (req_log.size() >= 2) begin
            check("wr_din_lo", 32'(req_log[0].din), 32'h0000F00D);
            check("wr_din_hi", 32'(req_log[1].din), 32'h0000CAFE);
            check("wr_we_ds", 32'({req_log[0].we, req_log[0].ds, req_log[1].we, req_log[1].ds}), 32'h3F);
        end

        // Empty halves are skipped
        req_log.delete();
        cpu_op(32'h0000_0100, 32'h12345678, 4'b1100);
        check("hi_only_count", 32'(req_log.size()), 32'd1);
        if (req_log.size() >= 1) check("hi_only_req", 32'(req_log[0]), 32'({20'h00081, 1'b1, 2'b11, 16'h1234}));
        req_log.delete();
        cpu_op(32'h0000_0100, 32'hAABBCCDD, 4'b0010);
        check("lo_only_count", 32'(req_log.size()), 32'd1);
        if (req_log.size() >= 1) check("lo_only_req", 32'(req_log[0]), 32'({20'h00080, 1'b1, 2'b10, 16'hCCDD}));
        cpu_op(32'h0000_0100, 32'h0, 4'b0000);
        check("merged_word", last_rdata, 32'h1234CC0D);

        // Ignored upper address bits, top-of-range word
        cpu_op(32'hFFE0_0008, 32'h11223344, 4'b0101);
        cpu_op(32'h0000_0008, 32'h0, 4'b0000);
        check("upper_bits_ignored", last_rdata, 32'h00220044);
        cpu_op(32'h001F_FFFC, 32'h9ABCDEF0, 4'b1111);
        cpu_op(32'h001F_FFFC, 32'h0, 4'b0000);

        // sdram_busy gates the start of a transaction
        sdram_busy = 1'b1;
        fork
            cpu_op(32'h0001_2344, 32'h0, 4'b0000);
            begin : busy_watch
                int toggles;
                int k;
                logic q0;
                q0 = rv_req;
                toggles = 0;
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (rv_req !== q0) toggles++;
                end
                check("busy_no_toggle", 32'(toggles), 32'h0);
                sdram_busy = 1'b0;
                k = 0;
                while (rv_req === q0 && k < 10) begin
                    @(negedge clk);
                    k++;
                end
                check("busy_release", 32'((k >= 1) && (k <= 2)), 32'h1);
            end
        join

        // Back-to-back reads with mem_valid held, reset during the second hi half
        expect_op(32'h0001_2344, 32'h0, 4'b0000);
        expect_op(32'h0001_2344, 32'h0, 4'b0000);
        mem_addr  = 32'h0001_2344;
        mem_wstrb = 4'b0000;
        mem_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mem_ready !== 1'b1 && n < 400);
        if (mem_ready !== 1'b1) fail_now("b2b_first_ready");
        r0 = rv_req;
        tg = 0;
        n  = 0;
        while (tg < 2 && n < 400) begin
            @(negedge clk);
            n++;
            if (rv_req !== r0) begin
                tg++;
                r0 = rv_req;
            end
        end
        if (tg < 2) fail_now("b2b_second_issue");
        @(negedge clk);
        resetn    = 1'b0;
        mem_valid = 1'b0;
        if (exp_rsp_q.size() > 0) pd = exp_rsp_q.pop_back();
        repeat (8) @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_req_aligned", 32'(rv_req), 32'(rv_req_ack));
        check("abort_no_ready", 32'(mem_ready), 32'h0);
        check("abort_reqs_drained", 32'(exp_req_q.size()), 32'h0);
        check("abort_rsp_drained", 32'(exp_rsp_q.size()), 32'h0);
        cpu_op(32'h0001_2344, 32'h0, 4'b0000);
        check("post_abort_read", last_rdata, 32'hDEADBEEF);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rv_sdram_bridge.md
Name: rv_sdram_bridge

Overview:
- Adapts the RISC-V softcore's 32-bit memory bus (valid/ready, byte strobes) to the SDRAM controller's 16-bit toggle-handshake RV port.
- Sits between the CPU and the SDRAM controller; the controller maps this port to SDRAM bank 2.
- Each 32-bit access becomes one or two 16-bit SDRAM transactions: low half first, then high half.
- Read halves are reassembled into a 32-bit word before mem_ready is asserted.

Parameters:
- RD_LAT, 3: clk cycles between observing rv_req_ack==rv_req and sampling rv_dout on a read half.
- SKIP_EMPTY_HALF, 1: on writes, a half whose two strobe bits are both 0 is not issued.

Ports:
- clk  in  1  controller clock.
- resetn  in  1  synchronous, active-low reset.
- mem_valid  in  1  CPU request valid; held stable until mem_ready.
- mem_addr  in  32  byte address; only [20:2] used, [1:0] and [31:21] ignored.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte strobes; 0000 = read.
- mem_rdata  out  32  read data, valid only while mem_ready=1.
- mem_ready  out  1  one-cycle completion pulse.
- sdram_busy  in  1  controller still initialising.
- rv_addr  out  20  [20:1] halfword address to controller.
- rv_din  out  16  write halfword.
- rv_ds  out  2  byte enables {hi,lo}.
- rv_we  out  1  1 = write.
- rv_req  out  1  toggle request.
- rv_req_ack  in  1  toggle acknowledge.
- rv_dout  in  16  read halfword.

Behaviour:
- Reset (resetn=0 at a clk edge):
  - Outputs: mem_ready=0, mem_rdata=0, rv_addr=0, rv_din=0, rv_ds=0, rv_we=0.
  - rv_req is loaded with the current rv_req_ack (the controller never resets its ack), so no request is pending.
  - State goes to IDLE; the latency counter clears.
- Reset mid-transaction abandons the access with no mem_ready. A halfword already toggled may still complete in the controller; that is harmless because it is ignored.
- Handshake: a request is pending while rv_req!=rv_req_ack. rv_addr, rv_din, rv_ds and rv_we must be stable from the toggle cycle until ack equality is observed. rv_req toggles only when rv_req==rv_req_ack.
- Halfword mapping:
  - lo half: rv_addr={mem_addr[20:2],1'b0}, rv_din=mem_wdata[15:0], rv_ds=mem_wstrb[1:0].
  - hi half: rv_addr={mem_addr[20:2],1'b1}, rv_din=mem_wdata[31:16], rv_ds=mem_wstrb[3:2].
  - Reads use rv_ds=2'b11 and rv_we=0.
- States:
  - IDLE: wait for mem_valid && !sdram_busy && !mem_ready. Latch the request. Go to LO_ISSUE, or to HI_ISSUE if this is a write, SKIP_EMPTY_HALF=1 and wstrb[1:0]==0.
  - LO_ISSUE / HI_ISSUE: drive the half's fields and toggle rv_req, then go to the matching WAIT state. This takes 1 cycle.
  - LO_WAIT / HI_WAIT: wait for rv_req_ack==rv_req.
    - Writes: move on immediately to HI_ISSUE (skipping if wstrb[3:2]==0 and SKIP_EMPTY_HALF=1) or to DONE.
    - Reads: load the counter with RD_LAT, decrement it to 0, capture rv_dout into the lo or hi 16 bits, then advance.
  - DONE: mem_ready=1 for exactly one cycle, mem_rdata=assembled word, return to IDLE.
- mem_ready must not re-trigger in the cycle after DONE even though mem_valid is still high; the !mem_ready guard in IDLE enforces this.
- A write with wstrb=0000 is by definition a read; a full write with all strobes 0 is impossible.
- sdram_busy asserting mid-transaction has no effect; it gates only the IDLE→issue step.
- Latency:
  - Read = 2 × (issue + controller round trip + RD_LAT) + 1.
  - Write = issued halves × (issue + round trip) + 1.
  - Controller round trip is bounded by its 6-cycle slot.
- rv_req_ack changing while no request is pending is a controller fault; the bridge ignores it.

Decomposition:
- Shared package holds:
  - state typedef (IDLE, LO_ISSUE, LO_WAIT, HI_ISSUE, HI_WAIT, DONE)
  - RV_RD_LAT default constant
  - RV_ADDR_MSB=20
- One sub-module is natural: toggle_req_port. It owns rv_req, the pending compare, reset alignment to ack, and the RD_LAT counter, and exposes issue/done pulses to the FSM.

Test Plan:
- Reset with rv_req_ack=1, resetn=0 for 2 clk, then 1 → rv_req=1, no toggle, mem_ready=0, all rv_* outputs 0.
- Read of 0x0001_2344 with controller model returning 0xBEEF (lo), 0xDEAD (hi):
  - rv_addr sequence 0x091A2 then 0x091A3, rv_we=0, rv_ds=11.
  - mem_rdata=0xDEADBEEF on a single mem_ready pulse.
- Write 0xCAFEF00D, wstrb=1111 → two toggles, rv_din 0xF00D then 0xCAFE, rv_ds 11 / 11, rv_we=1, one mem_ready.
- Write wstrb=1100 → only the hi half is issued (rv_addr LSB=1, rv_ds=11, rv_din=mem_wdata[31:16]). wstrb=0010 → only the lo half, rv_ds=10.
- sdram_busy=1 with mem_valid=1 for 50 cycles → no rv_req toggle. busy falls → request issues within 2 cycles.
- Back-to-back reads with mem_valid held high; resetn pulsed during HI_WAIT → no mem_ready, bridge in IDLE, rv_req==rv_req_ack after the controller acks.
